// File: rtl/arb21_ctrl_pkg.sv
// Shared types and helpers for the two-port round-robin burst arbiter.
package arb21_ctrl_pkg;

  // Arbiter ownership states: idle, or a grant held by port 0 / port 1.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Pick the next owner from IDLE; a tie goes to the port named by prio.
  function automatic state_e arb_pick(input logic v0, input logic v1, input logic prio);
    state_e pick;
    if (v0 && v1) begin
      pick = prio ? ST_OWN1 : ST_OWN0;
    end else if (v0) begin
      pick = ST_OWN0;
    end else if (v1) begin
      pick = ST_OWN1;
    end else begin
      pick = ST_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb21_ctrl_mux21.sv
// Plain 2:1 mux used to steer the owning requester's {last, data} beat.
module mux21 #(
  parameter int Size = 9
) (
  input  logic [Size-1:0] a0,
  input  logic [Size-1:0] a1,
  input  logic            sel,
  output logic [Size-1:0] y
);

  // Select port 1 when sel is high, port 0 otherwise.
  always_comb begin
    if (sel) begin
      y = a1;
    end else begin
      y = a0;
    end
  end

endmodule

// File: rtl/arb21_ctrl.sv
// Round-robin burst arbiter: grants whole bursts from two requesters to one
// downstream channel and registers the accepted beat into a one-entry stage.
module arb21_ctrl
  import arb21_ctrl_pkg::*;
#(
  parameter int Size     = 8,
  parameter int MaxBurst = 4,
  parameter int CntW     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v0,
  input  logic [Size-1:0] a0,
  input  logic            last0,
  output logic            rdy0,
  input  logic            v1,
  input  logic [Size-1:0] a1,
  input  logic            last1,
  output logic            rdy1,
  output logic [Size-1:0] y,
  output logic            y_last,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            s,
  output logic            busy
);

  // Beat count value at which the grant is forcibly released.
  localparam logic [CntW-1:0] CntLast = CntW'(MaxBurst - 1);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              s_q, s_d;
  logic [Size-1:0]   y_q, y_d;
  logic              y_last_q, y_last_d;
  logic              y_valid_q, y_valid_d;

  logic              out_free_s;
  logic              acc_s;
  logic [Size:0]     mux_out_s;

  // The owning port's {last, data} is steered by the current owner.
  mux21 #(.Size(Size + 1)) u_mux (
    .a0  ({last0, a0}),
    .a1  ({last1, a1}),
    .sel (s_q),
    .y   (mux_out_s)
  );

  // Ready to the owner only: the output stage is empty or draining this cycle.
  always_comb begin
    out_free_s = !y_valid_q || y_ready;
    rdy0       = (state_q == ST_OWN0) && out_free_s;
    rdy1       = (state_q == ST_OWN1) && out_free_s;
    acc_s      = (rdy0 && v0) || (rdy1 && v1);
  end

  // Next-state logic: arbitration in IDLE, beat counting and release while owning.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    case (state_q)
      ST_IDLE: begin
        state_d = arb_pick(v0, v1, prio_q);
        if (state_d == ST_OWN1) begin
          s_d = 1'b1;
        end else if (state_d == ST_OWN0) begin
          s_d = 1'b0;
        end else begin
          s_d = s_q;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (acc_s) begin
          if (mux_out_s[Size] || (cnt_q == CntLast)) begin
            // Release: the port that just finished loses the next tie.
            state_d = ST_IDLE;
            cnt_d   = {CntW{1'b0}};
            prio_d  = (state_q == ST_OWN0);
          end else begin
            cnt_d = cnt_q + {{(CntW-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CntW{1'b0}};
      end
    endcase
  end

  // Output stage: load on accept, empty when drained, otherwise hold.
  always_comb begin
    y_d       = y_q;
    y_last_d  = y_last_q;
    y_valid_d = y_valid_q;
    if (acc_s) begin
      y_d       = mux_out_s[Size-1:0];
      y_last_d  = mux_out_s[Size];
      y_valid_d = 1'b1;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end else begin
      y_valid_d = y_valid_q;
    end
  end

  // State and output registers; reset discards any in-flight beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prio_q    <= 1'b0;
      cnt_q     <= {CntW{1'b0}};
      s_q       <= 1'b0;
      y_q       <= {Size{1'b0}};
      y_last_q  <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      y_q       <= y_d;
      y_last_q  <= y_last_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign y_last  = y_last_q;
  assign y_valid = y_valid_q;
  assign s       = s_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arb21_ctrl.sv
// Randomized scoreboard bench for arb21_ctrl against a cycle-level rule model.
module tb_arb21_ctrl;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, last0, v1, last1, y_ready;
  logic [7:0] a0, a1;
  logic       rdy0, rdy1, y_last, y_valid, s, busy;
  logic [7:0] y;

  arb21_ctrl #(.Size(8), .MaxBurst(MAXB), .CntW(3)) dut (
    .clk(clk), .rst(rst),
    .v0(v0), .a0(a0), .last0(last0), .rdy0(rdy0),
    .v1(v1), .a1(a1), .last1(last1), .rdy1(rdy1),
    .y(y), .y_last(y_last), .y_valid(y_valid), .y_ready(y_ready),
    .s(s), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the channel (-1 none), beats taken, tie winner,
  // last granted port, and whether the output slot is full.
  int   m_owner, m_beats, m_prio, m_s;
  bit   m_ov, m_acc0, m_acc1;
  logic [8:0] exp_q[$];

  bit         prev_hold;
  logic [7:0] prev_y;
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_prio = 0; m_s = 0;
    m_ov = 1'b0; m_acc0 = 1'b0; m_acc1 = 1'b0;
    exp_q.delete();
    prev_hold = 1'b0;
  endtask

  // Model step: check handshake/owner outputs, then apply this cycle's rules.
  always @(negedge clk) begin
    bit er0, er1, acc, lst;
    int k;
    if (!rst) begin
      er0 = (m_owner == 0) && (!m_ov || y_ready);
      er1 = (m_owner == 1) && (!m_ov || y_ready);
      check("rdy0", {31'd0, rdy0}, {31'd0, er0});
      check("rdy1", {31'd0, rdy1}, {31'd0, er1});
      check("busy", {31'd0, busy}, (m_owner != -1) ? 32'd1 : 32'd0);
      check("s", {31'd0, s}, m_s);
      m_acc0 = er0 && v0;
      m_acc1 = er1 && v1;
      acc = m_acc0 || m_acc1;
      if (acc) begin
        k   = m_acc1 ? 1 : 0;
        lst = (k == 1) ? last1 : last0;
        exp_q.push_back((k == 1) ? {last1, a1} : {last0, a0});
        m_beats++;
        if (lst || m_beats == MAXB) begin
          m_owner = -1;
          m_beats = 0;
          m_prio  = 1 - k;
        end
      end else if (m_owner == -1) begin
        if (v0 && v1) m_owner = m_prio;
        else if (v0) m_owner = 0;
        else if (v1) m_owner = 1;
        if (m_owner != -1) m_s = m_owner;
      end
      m_ov = acc ? 1'b1 : (y_ready ? 1'b0 : m_ov);
    end
  end

  // Monitor: pop and compare each beat the DUT hands off, and check hold.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (prev_hold) begin
        check("hold_valid", {31'd0, y_valid}, 32'd1);
        check("hold_y", {24'd0, y}, {24'd0, prev_y});
        check("hold_last", {31'd0, y_last}, {31'd0, prev_last});
      end
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {23'd0, y_last, y}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("y", {24'd0, y}, {24'd0, e[7:0]});
          check("y_last", {31'd0, y_last}, {31'd0, e[8]});
        end
      end
      prev_hold = y_valid && !y_ready;
      prev_y    = y;
      prev_last = y_last;
    end
  end

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit iv0, input logic [7:0] ia0, input bit il0,
                        input bit iv1, input logic [7:0] ia1, input bit il1, input bit iyr);
    v0 = iv0; a0 = ia0; last0 = il0;
    v1 = iv1; a1 = ia1; last1 = il1;
    y_ready = iyr;
  endtask

  initial begin
    int seq, n, ok;
    logic [7:0] d0, d1;
    bit l0, l1;
    model_reset();
    rst = 1'b1;
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_s", {31'd0, s}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_rdy", {30'd0, rdy0, rdy1}, 32'd0);
    rst = 1'b0;

    // Reset mid-burst: port0 owns with two beats taken, then reset.
    ok = 0;
    seq = 8'h30;
    for (int i = 0; i < 20; i++) begin
      edge_tick();
      if (m_acc0) seq++;
      set_in(1'b1, 8'(seq), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      if (m_owner == 0 && m_beats == 2) begin ok = 1; break; end
    end
    check("reach_two_beats", ok, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_y_valid", {31'd0, y_valid}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_s", {31'd0, s}, 32'd0);
    model_reset();
    edge_tick();
    rst = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
    repeat (3) edge_tick();

    // Tie with single-beat bursts: strict alternation.
    for (int i = 0; i < 12; i++) begin
      set_in(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
      edge_tick();
    end

    // Long port0 burst with no last: forced release every MAXB beats.
    seq = 1;
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      edge_tick();
      if (m_acc0) seq++;
      set_in(seq <= 7, 8'(seq), seq == 7, 1'b0, 8'h00, 1'b0, 1'b1);
    end

    // Backpressure on a port1 burst, with a gap on port0 while port1 waits.
    seq = 0;
    for (int i = 0; i < 20; i++) begin
      edge_tick();
      if (m_acc1) seq++;
      set_in(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5 + 8'(seq), seq[0], !(i >= 4 && i < 7));
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      edge_tick();
      if (m_acc0) n++;
      set_in(!(i == 4 || i == 5) && n < 3, 8'h40 + 8'(n), n == 2, 1'b1, 8'h90, 1'b1, 1'b1);
    end

    // Port1 streaming alone in two-beat bursts.
    seq = 0;
    for (int i = 0; i < 16; i++) begin
      edge_tick();
      if (m_acc1) seq++;
      set_in(1'b0, 8'h00, 1'b0, 1'b1, 8'hC0 + 8'(seq), seq[0], 1'b1);
    end

    // Random traffic: data/last only change after the beat is taken.
    d0 = 8'($urandom); d1 = 8'($urandom); l0 = 1'b0; l1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      edge_tick();
      if (m_acc0) begin d0 = 8'($urandom); l0 = ($urandom_range(0, 2) == 0); end
      if (m_acc1) begin d1 = 8'($urandom); l1 = ($urandom_range(0, 2) == 0); end
      set_in($urandom_range(0, 3) != 0, d0, l0, $urandom_range(0, 3) != 0, d1, l1,
             $urandom_range(0, 9) < 7);
    end

    // Drain the output stage and confirm nothing was lost.
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (6) edge_tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
